ifetch_unit: RTL
================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the instruction buffer entries (legal values 2 or 4).
REQ-003 SHALL use one clock and a synchronous, active-low reset: CLK  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous active-low reset; state clears on a CLK edge while reset==0.
REQ-005 imem_req  output  1  instruction memory read request.
REQ-006 imem_addr  output  32  word-aligned read address; valid when imem_req==1.
REQ-007 imem_rdata  input  32  read data returned exactly one cycle after the request.
REQ-008 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-009 redirect_pc  input  32  new fetch target; sampled when redirect_valid==1.
REQ-010 inst_valid  output  1  buffer head holds a valid instruction.
REQ-011 inst  output  32  instruction word at the buffer head.
REQ-012 pc  output  32  address of inst.
REQ-013 inst_ready  input  1  downstream decode accepts the head.

Function
REQ-014 SHALL hold fetch_pc, a FIFO of {pc, inst} entries, one in-flight tag {valid, pc, epoch} and a 1-bit epoch.
REQ-015 SHALL assert imem_req with imem_addr=fetch_pc when the FIFO count plus in-flight count is below FIFO_DEPTH and no redirect is pending.
REQ-016 On each issued request, SHALL advance fetch_pc by 4 with modulo-2^32 wrap (32'hFFFFFFFC -> 32'h00000000).
REQ-017 One cycle after a request, SHALL push {tag pc, imem_rdata} into the FIFO only when the tag epoch equals the current epoch; otherwise it SHALL discard the response.
REQ-018 inst_valid SHALL equal FIFO non-empty; inst and pc SHALL be driven from the FIFO head; when empty they SHALL be 0.
REQ-019 The handshake SHALL complete when inst_valid and inst_ready are both 1; the head SHALL pop on that edge.
REQ-020 inst and pc SHALL remain stable while inst_valid==1 and inst_ready==0.
REQ-021 When a push and a pop occur in the same cycle, SHALL keep the count unchanged and preserve order.
REQ-022 A FIFO push SHALL never occur when full; the credit rule in REQ-015 guarantees this, and an assertion SHALL check it.
REQ-023 On redirect_valid==1 at an edge, SHALL:
- flush the FIFO;
- toggle the epoch;
- set fetch_pc = {redirect_pc[31:2], 2'b00};
- suppress imem_req in that same cycle.
REQ-024 Redirect latency SHALL be fixed: redirect at edge N -> imem_req with imem_addr=redirect target in cycle N+1 -> inst_valid=1 in cycle N+2.
REQ-025 If a redirect and a handshake coincide, SHALL count the handshake as consumed and then flush; pushes in that cycle SHALL be dropped.
REQ-026 Back-to-back redirects SHALL each take effect, with the last one determining fetch_pc.
REQ-027 With inst_ready held at 1 and no redirects, SHALL sustain one instruction per cycle after the initial 2-cycle fill.

Reset
REQ-028 While reset==0 at an edge, SHALL set:
- fetch_pc=RESET_PC, FIFO empty, in-flight invalid, epoch=0;
- inst_valid=0, inst=0, pc=0, imem_req=0.
REQ-029 SHALL issue the first request (imem_addr=RESET_PC) in the first cycle after reset is released.
REQ-030 Reset mid-operation SHALL discard in-flight responses and buffered entries with no push after release from pre-reset requests.

Verification
REQ-031 Release reset, hold inst_ready=1, memory returns word addr>>2 -> pc 0,4,8,12 on consecutive cycles from cycle 2, with inst matching each address.
REQ-032 Hold inst_ready=0 for 10 cycles -> exactly FIFO_DEPTH entries are buffered and imem_req drops to 0; release -> entries are delivered in order with no loss or duplication.
REQ-033 Redirect to 32'h00000103 while a request is in flight -> stale response dropped, next imem_addr=32'h00000100, and pc=32'h00000100 appears two cycles after the redirect.
REQ-034 Redirect coinciding with an accepted handshake -> the accepted instruction is not re-presented, the FIFO is empty the next cycle, and the new stream starts at the target.
REQ-035 Redirect to 32'hFFFFFFF8 with inst_ready=1 -> pc sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-036 Assert reset for one cycle with the FIFO full and a request in flight -> inst_valid=0 the next cycle, and the first output after release has pc=RESET_PC.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - fetch unit bus bundle: instruction memory, redirect and decode handshake
//
// Purpose: groups every non-clock/reset signal of ifetch_unit.
// Signals:
//   imem_req/imem_addr     fetch unit -> instruction memory read request, word address
//   imem_rdata             instruction memory -> fetch unit, data one cycle after request
//   redirect_valid/_pc     control flow -> fetch unit, flush and refetch at target
//   inst_valid/inst/pc     fetch unit -> decode, buffer head
//   inst_ready             decode -> fetch unit, head accepted
// Modports: master = fetch unit side, slave = environment side.
interface ifetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, pc,
    input  imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, pc,
    output imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch unit with credit-limited prefetch buffer and redirect flush
//
// Purpose: issues sequential word reads to a one-cycle-latency instruction
// memory, buffers returned words with their addresses, presents the head to
// decode, and flushes/refetches on a redirect.
// Ports:
//   CLK    rising-edge clock
//   reset  synchronous active-low reset
//   bus    ifetch_unit_if.master (imem_*, redirect_*, inst_valid/inst/pc, inst_ready)
// Parameters: RESET_PC first fetch address, FIFO_DEPTH buffer entries (2 or 4).
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic          CLK,
  input  logic          reset,
  ifetch_unit_if.master bus
);
  localparam int           PW      = $clog2(FIFO_DEPTH);
  localparam int           CW      = PW + 1;
  localparam logic [CW:0]  DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          epoch_q, epoch_d;
  logic          infl_valid_q, infl_valid_d;
  logic [31:0]   infl_pc_q, infl_pc_d;
  logic          infl_epoch_q, infl_epoch_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]   fifo_inst_q [FIFO_DEPTH];

  logic          empty, pop, push, req;
  logic [CW:0]   cnt_after_pop, credit_sum;

  always_comb begin
    empty         = (count_q == '0);
    pop           = !empty && bus.inst_ready;
    // A head leaving this cycle frees its slot for the request issued now,
    // which is what lets a full-rate stream keep one request in flight.
    cnt_after_pop = (CW+1)'(count_q) - (CW+1)'(pop);
    credit_sum    = cnt_after_pop + (CW+1)'(infl_valid_q);
    req           = reset && !bus.redirect_valid && (credit_sum < DEPTH_C);
    // Responses tagged with an old epoch, or landing on a redirect edge, are dropped.
    push          = infl_valid_q && (infl_epoch_q == epoch_q) && !bus.redirect_valid;

    fetch_pc_d   = fetch_pc_q;
    epoch_d      = epoch_q;
    infl_valid_d = req;
    infl_pc_d    = fetch_pc_q;
    infl_epoch_d = epoch_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q + CW'(push) - CW'(pop);

    if (req)  fetch_pc_d = fetch_pc_q + 32'd4;
    if (pop)  rd_ptr_d   = rd_ptr_q + 1'b1;
    if (push) wr_ptr_d   = wr_ptr_q + 1'b1;

    if (bus.redirect_valid) begin
      fetch_pc_d   = bus.redirect_pc & 32'hFFFF_FFFC;
      epoch_d      = ~epoch_q;
      infl_valid_d = 1'b0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      fetch_pc_q   <= RESET_PC;
      epoch_q      <= 1'b0;
      infl_valid_q <= 1'b0;
      infl_pc_q    <= 32'h0;
      infl_epoch_q <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      epoch_q      <= epoch_d;
      infl_valid_q <= infl_valid_d;
      infl_pc_q    <= infl_pc_d;
      infl_epoch_q <= infl_epoch_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // Entry storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge CLK) begin
    if (reset && push) begin
      fifo_pc_q[wr_ptr_q]   <= infl_pc_q;
      fifo_inst_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset && push) begin
      assert (cnt_after_pop < DEPTH_C);
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.inst_valid = !empty;
  assign bus.inst       = empty ? 32'h0 : fifo_inst_q[rd_ptr_q];
  assign bus.pc         = empty ? 32'h0 : fifo_pc_q[rd_ptr_q];
endmodule
